// File: rtl/match_indexer.sv
// match_indexer
//   Scans a VECTOR_SIZE-bit match vector and streams the position of every set
//   bit (as bit index + 1), lowest first, one per cycle, followed by a
//   terminator word 0. Results go through a first-word-fall-through FIFO.
//
// Parameters: VECTOR_SIZE (multiple of SEG_WIDTH), SEG_WIDTH (power of 2),
//   FIFO_DEPTH (power of 2, >= 2), IDX_W (derived output word width).
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   ld, i_din     load strobe and match vector (taken only when busy=0)
//   busy          a vector is being scanned
//   drop          one-cycle pulse after an ld that arrived while busy
//   rd_en         pop FIFO head (ignored when empty)
//   o_dout        FIFO head, valid when empty=0
//   empty, full   registered FIFO status
//   drop_cnt      saturating count of drop pulses (INDEXER_STATS_EN only)
// Optional feature macro: INDEXER_STATS_EN
module match_indexer #(
  parameter int VECTOR_SIZE = 256,
  parameter int SEG_WIDTH   = 32,
  parameter int FIFO_DEPTH  = 16,
  localparam int IDX_W      = $clog2(VECTOR_SIZE + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ld,
  input  logic [VECTOR_SIZE-1:0] i_din,
  output logic                   busy,
  output logic                   drop,
  input  logic                   rd_en,
  output logic [IDX_W-1:0]       o_dout,
  output logic                   empty,
  output logic                   full
`ifdef INDEXER_STATS_EN
  ,
  output logic [15:0]            drop_cnt
`endif
);

  localparam int NSEG  = VECTOR_SIZE / SEG_WIDTH;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                 state_q, state_d;
  logic [VECTOR_SIZE-1:0] vec_q, vec_d;
  logic                   drop_q, drop_d;

  logic [IDX_W-1:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   full_q, full_d, empty_q, empty_d;

  logic                   wr_en, rd_do;
  logic [IDX_W-1:0]       wr_word;

  // Two-level priority encoder: lowest non-zero segment, then lowest bit in it.
  logic [NSEG-1:0][SEG_WIDTH-1:0] segs;
  logic [SEG_WIDTH-1:0]           seg_bits;
  logic                           seg_found, bit_found;
  int                             sel_seg, sel_bit, hit_pos;

  assign segs = vec_q;

  always_comb begin
    seg_found = 1'b0;
    sel_seg   = 0;
    seg_bits  = '0;
    for (int s = 0; s < NSEG; s++) begin
      if (!seg_found && (segs[s] != '0)) begin
        seg_found = 1'b1;
        sel_seg   = s;
        seg_bits  = segs[s];
      end
    end
    bit_found = 1'b0;
    sel_bit   = 0;
    for (int b = 0; b < SEG_WIDTH; b++) begin
      if (!bit_found && seg_bits[b]) begin
        bit_found = 1'b1;
        sel_bit   = b;
      end
    end
    hit_pos = sel_seg * SEG_WIDTH + sel_bit;
  end

  // Scanner FSM
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    wr_en   = 1'b0;
    wr_word = '0;
    drop_d  = ld && (state_q == SCAN);
    case (state_q)
      IDLE: begin
        if (ld) begin
          vec_d   = i_din;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // A full FIFO freezes the scan; nothing is written or cleared.
        if (!full_q) begin
          wr_en = 1'b1;
          if (vec_q != '0) begin
            wr_word = IDX_W'(hit_pos + 1);
            vec_d   = vec_q & ~({{(VECTOR_SIZE-1){1'b0}}, 1'b1} << hit_pos);
          end else begin
            wr_word = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping; status flags are registered from the next count.
  always_comb begin
    rd_do    = rd_en && !empty_q;
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_do ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(wr_en) - CNT_W'(rd_do);
    full_d   = (cnt_d == CNT_W'(FIFO_DEPTH));
    empty_d  = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      drop_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: o_dout is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_word;
  end

  assign busy   = (state_q == SCAN);
  assign drop   = drop_q;
  assign empty  = empty_q;
  assign full   = full_q;
  assign o_dout = empty_q ? '0 : mem_q[rd_ptr_q];

`ifdef INDEXER_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_q && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_match_indexer.sv
// Self-checking bench for match_indexer (VECTOR_SIZE=256, SEG_WIDTH=32,
// FIFO_DEPTH=4 so the full-stall path is reachable). Expected words come from
// a bit-order model pushed into a queue on each load and popped by a monitor
// whenever the bench reads the FIFO.
module tb_match_indexer;

  localparam int VS = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld = 1'b0;
  logic [VS-1:0] i_din = '0;
  logic          busy, drop, rd_en, empty, full;
  logic [8:0]    o_dout;
`ifdef INDEXER_STATS_EN
  logic [15:0]   drop_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  match_indexer #(.VECTOR_SIZE(VS), .SEG_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ld(ld), .i_din(i_din), .busy(busy), .drop(drop),
    .rd_en(rd_en), .o_dout(o_dout), .empty(empty), .full(full)
`ifdef INDEXER_STATS_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_model(input logic [VS-1:0] v);
    for (int k = 0; k < VS; k++) if (v[k]) exp_q.push_back(k + 1);
    exp_q.push_back(0);
  endtask

  // Scoreboard: every real pop is compared against the model.
  always @(negedge clk) begin
    if (!rst && rd_en && !empty) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL pop_unexpected: got word %0d expected no word", o_dout);
      end else begin
        check("pop_word", 32'(o_dout), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle_drained(input string nm);
    int g = 0;
    while ((busy || exp_q.size() != 0) && g < 600) begin step(); g++; end
    check({nm, "_drained"}, 32'(exp_q.size()), 0);
    check({nm, "_idle"}, 32'(busy), 0);
  endtask

  // Load one vector with rd_en=1 and check fall-through latency and busy length.
  task automatic run_vec(input logic [VS-1:0] v, input int exp_n, input int exp_first, input string nm);
    int cyc;
    check({nm, "_busy_pre"}, 32'(busy), 0);
    push_model(v);
    ld = 1'b1; i_din = v;
    step();
    ld = 1'b0;
    check({nm, "_busy_t1"}, 32'(busy), 1);
    check({nm, "_empty_t1"}, 32'(empty), 1);
    cyc = 1;
    step();
    check({nm, "_empty_t2"}, 32'(empty), 0);
    check({nm, "_first"}, 32'(o_dout), 32'(exp_first));
    while (busy && cyc < 400) begin cyc++; step(); end
    check({nm, "_busy_len"}, 32'(cyc), 32'(exp_n + 1));
    wait_idle_drained(nm);
  endtask

  typedef struct {
    logic [VS-1:0] din;
    int            exp_n;
    int            exp_first;
    string         nm;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VS-1:0] v;
    int g;
    rd_en = 1'b1;

    v = '0; v[0] = 1'b1; v[5] = 1'b1; v[255] = 1'b1;
    tbl[0] = '{v, 3, 1, "bits_0_5_255"};
    tbl[1] = '{'0, 0, 0, "zero_vec"};
    v = '0; v[31] = 1'b1; v[32] = 1'b1; v[63] = 1'b1; v[64] = 1'b1;
    tbl[2] = '{v, 4, 32, "seg_bound"};
    v = '0; v[255] = 1'b1;
    tbl[3] = '{v, 1, 256, "top_bit"};
    v = '0; v[7:4] = 4'hF;
    tbl[4] = '{v, 4, 5, "bits_4_7"};

    repeat (3) step();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_drop", 32'(drop), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_dout", 32'(o_dout), 0);
`ifdef INDEXER_STATS_EN
    check("rst_drop_cnt", 32'(drop_cnt), 0);
`endif

    for (int i = 0; i < 5; i++) begin
      run_vec(tbl[i].din, tbl[i].exp_n, tbl[i].exp_first, tbl[i].nm);
      step();
    end

    // Full stall: all bits set with no reads until the FIFO fills.
    rd_en = 1'b0;
    v = '1;
    push_model(v);
    ld = 1'b1; i_din = v;
    step();
    ld = 1'b0;
    repeat (8) step();
    check("stall_full", 32'(full), 1);
    check("stall_busy", 32'(busy), 1);
    check("stall_head", 32'(o_dout), 1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("stall_unfull", 32'(full), 0);
    check("stall_head2", 32'(o_dout), 2);
    step();
    check("stall_refull", 32'(full), 1);
    rd_en = 1'b1;
    wait_idle_drained("stall");
    step();
    check("stall_empty_end", 32'(empty), 1);

    // Reset mid-scan flushes the FIFO and abandons the vector.
    v = '0; v[20:10] = '1;
    push_model(v);
    ld = 1'b1; i_din = v;
    step();
    ld = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_empty", 32'(empty), 1);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_full", 32'(full), 0);
    check("mid_rst_dout", 32'(o_dout), 0);
    v = '0; v[7] = 1'b1;
    run_vec(v, 1, 8, "after_rst");
    step();

    // Drop: second ld while busy is discarded and pulses drop once.
    v = '0; v[1] = 1'b1; v[2] = 1'b1;
    push_model(v);
    ld = 1'b1; i_din = v;
    step();
    i_din = '1;
    check("drop_t1", 32'(drop), 0);
    step();
    ld = 1'b0;
    check("drop_t2", 32'(drop), 1);
    step();
    check("drop_t3", 32'(drop), 0);
    wait_idle_drained("drop");
    g = 0;
    while (g < 5) begin step(); g++; end
    check("drop_no_extra", 32'(empty), 1);
`ifdef INDEXER_STATS_EN
    check("drop_cnt", 32'(drop_cnt), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
